i2c_target_regs: RTL and testbench

I2C target (responder) with an internal byte-wide register file; the counterpart of the team's I2C master on the shared SCL/SDA bus. It oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit address, accepts pointer-plus-data writes and returns register contents on reads. SDA is driven open-drain through `sda_oe`. A write strobe exposes every register update to the surrounding logic.

---
 rtl/i2c_target_regs.sv | 205 ++++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regs.sv
// I2C target with a byte-wide register file: pointer-then-data writes, auto-incrementing reads.
// Pins to decision: 3 clk. The bus is the only source of backpressure; SCL is never stretched.
module i2c_target_regs #(
   parameter logic [6:0] ADDR  = 7'h55,
   parameter int         NREGS = 4,
   localparam int        PW    = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          scl,
   input  logic          sda_in,
   output logic          sda_oe,
   output logic          busy,
   output logic          wr_valid,
   output logic [PW-1:0] wr_addr,
   output logic [7:0]    wr_data
);

   typedef enum logic [2:0] {
      IDLE, ADDR_ST, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
   } state_t;

   state_t        state_q, state_d;
   logic          scl_s1, scl_s2, scl_d;
   logic          sda_s1, sda_s2, sda_d;
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shreg_q, shreg_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic          first_q, first_d;
   logic          ack_q, ack_d;
   logic          sda_oe_d;
   logic          byte_done_q, byte_done_d;
   logic          busy_set;
   logic [7:0]    regs [NREGS];
   logic [7:0]    rd_byte;
   logic [2:0]    rd_idx;

   // Bus conditions are evaluated on the synchronised copies only.
   wire scl_rise  = scl_s2 & ~scl_d;
   wire scl_fall  = ~scl_s2 & scl_d;
   wire start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
   wire stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shreg_d     = shreg_q;
      ptr_d       = ptr_q;
      first_d     = first_q;
      ack_d       = ack_q;
      sda_oe_d    = sda_oe;
      byte_done_d = 1'b0;
      busy_set    = 1'b0;
      rd_byte     = regs[ptr_q];
      rd_idx      = 3'd7 - bit_cnt_q[2:0];

      if (byte_done_q)
         ptr_d = ptr_q + PW'(1);

      if (start_det) begin
         state_d   = ADDR_ST;
         bit_cnt_d = 4'd0;
         sda_oe_d  = 1'b0;
      end else if (stop_det) begin
         state_d  = IDLE;
         sda_oe_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: ;
            ADDR_ST: begin
               if (scl_rise) begin
                  shreg_d   = {shreg_q[6:0], sda_s2};
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (scl_fall && bit_cnt_q == 4'd8) begin
                  if (shreg_q[7:1] == ADDR) begin
                     sda_oe_d = 1'b1;
                     busy_set = 1'b1;
                     state_d  = ADDR_ACK;
                  end else begin
                     state_d = WAIT_STOP;
                  end
               end
            end
            ADDR_ACK: begin
               if (scl_fall) begin
                  if (shreg_q[0]) begin
                     sda_oe_d  = ~rd_byte[7];
                     bit_cnt_d = 4'd1;
                     state_d   = RD_BYTE;
                  end else begin
                     sda_oe_d  = 1'b0;
                     bit_cnt_d = 4'd0;
                     first_d   = 1'b1;
                     state_d   = WR_BYTE;
                  end
               end
            end
            WR_BYTE: begin
               if (scl_rise) begin
                  shreg_d   = {shreg_q[6:0], sda_s2};
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  // The register write itself lands one cycle later from shreg_q.
                  if (bit_cnt_q == 4'd7 && !first_q)
                     byte_done_d = 1'b1;
               end else if (scl_fall && bit_cnt_q == 4'd8) begin
                  if (first_q) begin
                     ptr_d   = shreg_q[PW-1:0];
                     first_d = 1'b0;
                  end
                  sda_oe_d = 1'b1;
                  state_d  = WR_ACK;
               end
            end
            WR_ACK: begin
               if (scl_fall) begin
                  sda_oe_d  = 1'b0;
                  bit_cnt_d = 4'd0;
                  state_d   = WR_BYTE;
               end
            end
            RD_BYTE: begin
               if (scl_fall) begin
                  if (bit_cnt_q == 4'd8) begin
                     sda_oe_d = 1'b0;
                     state_d  = RD_ACK;
                  end else begin
                     sda_oe_d  = ~rd_byte[rd_idx];
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end
               end
            end
            RD_ACK: begin
               if (scl_rise) begin
                  ack_d = ~sda_s2;
                  if (!sda_s2)
                     ptr_d = ptr_q + PW'(1);
               end else if (scl_fall) begin
                  // ptr_q already points at the next register here.
                  if (ack_q) begin
                     sda_oe_d  = ~rd_byte[7];
                     bit_cnt_d = 4'd1;
                     state_d   = RD_BYTE;
                  end else begin
                     sda_oe_d = 1'b0;
                     state_d  = WAIT_STOP;
                  end
               end
            end
            WAIT_STOP: sda_oe_d = 1'b0;
            default:   state_d  = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         scl_s1      <= 1'b1;
         scl_s2      <= 1'b1;
         scl_d       <= 1'b1;
         sda_s1      <= 1'b1;
         sda_s2      <= 1'b1;
         sda_d       <= 1'b1;
         state_q     <= IDLE;
         bit_cnt_q   <= 4'd0;
         shreg_q     <= 8'h00;
         ptr_q       <= '0;
         first_q     <= 1'b0;
         ack_q       <= 1'b0;
         sda_oe      <= 1'b0;
         byte_done_q <= 1'b0;
         busy        <= 1'b0;
         wr_valid    <= 1'b0;
         wr_addr     <= '0;
         wr_data     <= 8'h00;
         for (int i = 0; i < NREGS; i++)
            regs[i] <= 8'h00;
      end else begin
         scl_s1      <= scl;
         scl_s2      <= scl_s1;
         scl_d       <= scl_s2;
         sda_s1      <= sda_in;
         sda_s2      <= sda_s1;
         sda_d       <= sda_s2;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shreg_q     <= shreg_d;
         ptr_q       <= ptr_d;
         first_q     <= first_d;
         ack_q       <= ack_d;
         sda_oe      <= sda_oe_d;
         byte_done_q <= byte_done_d;
         wr_valid    <= byte_done_q;
         if (busy_set)
            busy <= 1'b1;
         else if (state_q == IDLE)
            busy <= 1'b0;
         if (byte_done_q) begin
            regs[ptr_q] <= shreg_q;
            wr_addr     <= ptr_q;
            wr_data     <= shreg_q;
         end
      end
   end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bus master tasks drive the pins; write strobes go through a scoreboard.
module tb_i2c_target_regs;
   localparam int PW = 2;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          scl = 1'b1;
   logic          m_sda = 1'b1;
   logic          sda_in;
   logic          sda_oe, busy, wr_valid;
   logic [PW-1:0] wr_addr;
   logic [7:0]    wr_data;

   assign sda_in = m_sda & ~sda_oe;
   always #5 clk = ~clk;

   i2c_target_regs #(.ADDR(7'h55), .NREGS(4)) dut (
      .clk(clk), .reset_n(reset_n), .scl(scl), .sda_in(sda_in), .sda_oe(sda_oe),
      .busy(busy), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   typedef struct packed { logic [PW-1:0] a; logic [7:0] d; } wr_t;
   wr_t exp_q[$];
   int  tests = 0;
   int  fails = 0;
   logic oe_seen = 1'b0, busy_seen = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Write-strobe monitor plus SDA drive timing relative to SCL edges.
   logic scl_prev = 1'b1, oe_prev = 1'b0, wr_prev = 1'b0, busy_prev = 1'b0;
   int   rise_age = 100, fall_age = 100;
   always @(posedge clk) begin
      #1;
      rise_age = (scl && !scl_prev) ? 1 : rise_age + 1;
      fall_age = (!scl && scl_prev) ? 1 : fall_age + 1;
      scl_prev = scl;
      if (sda_oe) oe_seen = 1'b1;
      if (busy) busy_seen = 1'b1;
      if (reset_n && sda_oe != oe_prev)
         check("oe_change_3clk_after_fall", fall_age, 3);
      if (reset_n && busy && !busy_prev)
         check("busy_rises_with_ack", sda_oe, 1'b1);
      oe_prev   = sda_oe;
      busy_prev = busy;
      if (wr_valid) begin
         wr_t e;
         check("wr_valid_one_cycle", wr_prev, 1'b0);
         check("wr_valid_4clk_after_rise", rise_age, 4);
         if (exp_q.size() == 0) begin
            check("wr_unexpected", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", wr_addr, e.a);
            check("wr_data", wr_data, e.d);
         end
      end
      wr_prev = wr_valid;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_start();
      m_sda = 1'b1; tick(4);
      scl   = 1'b1; tick(4);
      m_sda = 1'b0; tick(4);
      scl   = 1'b0; tick(4);
   endtask

   task automatic bus_stop(input bit timed);
      m_sda = 1'b0; tick(4);
      scl   = 1'b1; tick(4);
      m_sda = 1'b1;
      if (timed) begin
         tick(3); check("busy_held_3clk_after_stop", busy, 1'b1);
         tick(1); check("busy_low_4clk_after_stop", busy, 1'b0);
         tick(4);
      end else begin
         tick(8);
      end
   endtask

   task automatic clock_bit(input logic b, output logic seen);
      m_sda = b; tick(4);
      scl   = 1'b1; tick(4);
      seen  = sda_in; tick(4);
      scl   = 1'b0; tick(4);
   endtask

   task automatic send_byte(input logic [7:0] v, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) clock_bit(v[i], s);
      clock_bit(1'b1, s);
      ack = ~s;
   endtask

   task automatic recv_byte(input logic nack, output logic [7:0] v);
      logic s;
      v = 8'h00;
      for (int i = 0; i < 8; i++) begin
         clock_bit(1'b1, s);
         v = {v[6:0], s};
      end
      clock_bit(nack, s);
   endtask

   task automatic put(input string name, input logic [7:0] v, input logic exp_ack);
      logic ack;
      send_byte(v, ack);
      check(name, ack, exp_ack);
   endtask

   task automatic get(input string name, input logic nack, input logic [7:0] exp);
      logic [7:0] v;
      recv_byte(nack, v);
      check(name, v, exp);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      tick(4);
      reset_n = 1'b1;
      tick(2);
      check("rst_sda_oe", sda_oe, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_wr_valid", wr_valid, 1'b0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 8'h00);

      // Plain write: pointer 1, data 0xCC.
      bus_start();
      put("w_addr_ack", 8'hAA, 1'b1);
      check("w_busy_after_match", busy, 1'b1);
      put("w_ptr_ack", 8'h01, 1'b1);
      exp_q.push_back(wr_t'{a: 2'd1, d: 8'hCC});
      put("w_data_ack", 8'hCC, 1'b1);
      bus_stop(1'b1);

      // Preload reg2, then pointer write + repeated START read.
      bus_start();
      put("p_addr_ack", 8'hAA, 1'b1);
      put("p_ptr_ack", 8'h02, 1'b1);
      exp_q.push_back(wr_t'{a: 2'd2, d: 8'h33});
      put("p_data_ack", 8'h33, 1'b1);
      bus_stop(1'b0);
      bus_start();
      put("r_waddr_ack", 8'hAA, 1'b1);
      put("r_ptr_ack", 8'h01, 1'b1);
      bus_start();
      put("r_raddr_ack", 8'hAB, 1'b1);
      get("r_byte1", 1'b0, 8'hCC);
      get("r_byte2", 1'b1, 8'h33);
      check("r_oe_after_nack", sda_oe, 1'b0);
      bus_stop(1'b0);
      check("r_busy_after_stop", busy, 1'b0);

      // Address mismatch: nothing acknowledged, no writes, never busy.
      oe_seen = 1'b0;
      busy_seen = 1'b0;
      bus_start();
      put("mm_addr_nack", 8'hA8, 1'b0);
      put("mm_b1_nack", 8'h00, 1'b0);
      put("mm_b2_nack", 8'h11, 1'b0);
      bus_stop(1'b0);
      check("mm_oe_never", oe_seen, 1'b0);
      check("mm_busy_never", busy_seen, 1'b0);

      // Pointer wrap across the top of the register file.
      bus_start();
      put("wr_addr_ack", 8'hAA, 1'b1);
      put("wr_ptr_ack", 8'h03, 1'b1);
      exp_q.push_back(wr_t'{a: 2'd3, d: 8'h10});
      put("wr_d1_ack", 8'h10, 1'b1);
      exp_q.push_back(wr_t'{a: 2'd0, d: 8'h20});
      put("wr_d2_ack", 8'h20, 1'b1);
      exp_q.push_back(wr_t'{a: 2'd1, d: 8'h30});
      put("wr_d3_ack", 8'h30, 1'b1);
      bus_stop(1'b0);
      bus_start();
      put("wrr_waddr_ack", 8'hAA, 1'b1);
      put("wrr_ptr_ack", 8'h03, 1'b1);
      bus_start();
      put("wrr_raddr_ack", 8'hAB, 1'b1);
      get("wrr_reg3", 1'b0, 8'h10);
      get("wrr_reg0", 1'b0, 8'h20);
      get("wrr_reg1", 1'b1, 8'h30);
      bus_stop(1'b0);

      // STOP in the middle of a data byte discards it.
      begin
         logic s;
         bus_start();
         put("ab_addr_ack", 8'hAA, 1'b1);
         put("ab_ptr_ack", 8'h00, 1'b1);
         for (int i = 0; i < 4; i++) clock_bit(1'b1, s);
         bus_stop(1'b0);
      end
      bus_start();
      put("abr_waddr_ack", 8'hAA, 1'b1);
      put("abr_ptr_ack", 8'h00, 1'b1);
      bus_start();
      put("abr_raddr_ack", 8'hAB, 1'b1);
      get("abr_reg0_kept", 1'b1, 8'h20);
      bus_stop(1'b0);

      // Pointer byte above NREGS keeps only its low bits: 0x06 -> reg2.
      bus_start();
      put("tr_addr_ack", 8'hAA, 1'b1);
      put("tr_ptr_ack", 8'h06, 1'b1);
      exp_q.push_back(wr_t'{a: 2'd2, d: 8'h5A});
      put("tr_data_ack", 8'h5A, 1'b1);
      bus_stop(1'b0);
      bus_start();
      put("trr_waddr_ack", 8'hAA, 1'b1);
      put("trr_ptr_ack", 8'h02, 1'b1);
      bus_start();
      put("trr_raddr_ack", 8'hAB, 1'b1);
      get("trr_reg2", 1'b1, 8'h5A);
      bus_stop(1'b0);

      // Reset while driving a 0 data bit of reg2 (0x5A).
      bus_start();
      put("rs_raddr_ack", 8'hAB, 1'b1);
      check("rs_oe_driving", sda_oe, 1'b1);
      #2 reset_n = 1'b0;
      #1 check("rs_oe_released_async", sda_oe, 1'b0);
      check("rs_busy_cleared", busy, 1'b0);
      check("rs_wr_data_cleared", wr_data, 8'h00);
      tick(2);
      reset_n = 1'b1;
      m_sda = 1'b1; tick(2);
      scl = 1'b1; tick(8);
      bus_start();
      put("rs2_raddr_ack", 8'hAB, 1'b1);
      get("rs2_reg0_zero", 1'b0, 8'h00);
      get("rs2_reg1_zero", 1'b1, 8'h00);
      bus_stop(1'b0);

      tick(8);
      check("wr_queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
